instr_sequencer: RTL
====================

# instr_sequencer

Fetch/decode/execute controller for the 16-bit GPR processor datapath. Fetches 32-bit instruction words from a synchronous program memory, drives the datapath instruction register, and issues one-cycle execute strobes. Resolves jump, conditional-jump and halt opcodes itself using the flags the datapath returns. Sits between program memory and the datapath, replacing direct testbench loading of the instruction register.

## Interface
- ADDR_W, 5, program-memory address width and PC width (32 instructions)
- INSN_W, 32, instruction width; fixed field layout below
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins execution from PC 0 when idle or halted
- imem_addr  out  ADDR_W  program-memory read address
- imem_rdata  in  INSN_W  read data, valid one cycle after imem_addr
- ir_o  out  INSN_W  instruction register to datapath
- exec_en  out  1  one-cycle strobe; datapath commits ir_o on this edge
- flags_i  in  4  {sign, zero, overflow, carry}; valid the cycle after exec_en
- pc  out  ADDR_W  current program counter
- busy  out  1  high in FETCH/LOAD/EXEC/NEXT
- halted  out  1  high in HALT

## Operation
- Instruction fields: oper_type [31:27], rdst [26:22], rsrc1 [21:17], imm_mode [16], rsrc2 [15:11], isrc [15:0]; jump target = isrc[ADDR_W-1:0].
- Sequencer-owned opcodes: 12 JMP, 13 JC, 14 JNC, 15 JS, 16 JNS, 17 JZ, 18 JNZ, 19 JV, 20 JNV, 21 HLT. All other opcodes go to the datapath.
- States: IDLE, FETCH, LOAD, EXEC, NEXT, HALT.
- IDLE: start -> FETCH, pc=0, flag register cleared. Other inputs ignored.
- FETCH: imem_addr=pc -> LOAD.
- LOAD: ir_o <= imem_rdata -> EXEC.
- EXEC: datapath opcode -> exec_en=1 this cycle. Jump opcode -> condition evaluated against the flag register; exec_en stays 0. HLT -> HALT; pc unchanged; exec_en stays 0.
- NEXT: after a datapath op, flag register <= flags_i. pc <= target if the jump was taken, else pc+1 -> FETCH.
- Jumps do not modify flags. Conditional jumps use the flags from the most recent datapath instruction.
- HALT: halted=1. start -> FETCH with pc=0 and flags cleared.
- start while busy is ignored.

## Timing
- 4 cycles per instruction (FETCH, LOAD, EXEC, NEXT). exec_en is never asserted on consecutive cycles.
- First exec_en occurs 3 cycles after the start pulse is sampled.
- pc wraps from 2^ADDR_W-1 to 0 on an untaken or sequential advance.
- A jump whose target equals its own pc is legal and loops forever.
- Reset values: pc=0, imem_addr=0, ir_o=0, exec_en=0, busy=0, halted=0, flags=0, state IDLE.
- Reset asserted mid-instruction drops exec_en immediately (asynchronously). No partial pc update survives reset.
- start coincident with reset release is ignored.

## Structure
- Shared package (proc_pkg) holds:
  - field bit positions
  - opcode constants, including datapath opcodes 1 MOV, 2 ADD, 4 MUL, 6 AND, 11 NOT
  - state encoding
  - flag index constants
- Sub-module branch_eval (combinational): inputs oper_type and the 4-bit flag register; outputs is_jump, taken, is_halt.
- Everything else lives in instr_sequencer (FSM, pc, ir, flag register). Expected size: ~200 lines.

## Test plan
- Memory {ADDI r0,r2,#5 ; HLT}, start -> exec_en exactly once, 3 cycles after start; then halted=1 with pc=1, and ir_o holds HLT.
- Program runs ADD producing carry (flags_i=4'b0001), then JC to 7 -> pc=7 in the NEXT cycle; JNC in the same position falls through to pc+1.
- JZ with flags zero=0 -> not taken. A following ADD returns zero=1; a second JZ to 3 -> taken, pc=3.
- pc=31 holding a datapath op -> next fetch address 0.
- Reset pulsed during EXEC with exec_en high -> exec_en, busy and pc read 0 immediately; state IDLE. A subsequent start restarts at address 0.
- start pulses while busy are ignored. start in HALT restarts at pc=0 with flags cleared.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the instruction sequencer: field layout, opcodes,
// flag bit positions and the sequencer state encoding.
package proc_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_INSN_W = 32;

  localparam int OPER_HI      = 31;
  localparam int OPER_LO      = 27;
  localparam int RDST_HI      = 26;
  localparam int RDST_LO      = 22;
  localparam int RSRC1_HI     = 21;
  localparam int RSRC1_LO     = 17;
  localparam int IMM_MODE_BIT = 16;
  localparam int RSRC2_HI     = 15;
  localparam int RSRC2_LO     = 11;
  localparam int ISRC_HI      = 15;
  localparam int ISRC_LO      = 0;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_MOV = 5'd1;
  localparam opcode_t OP_ADD = 5'd2;
  localparam opcode_t OP_MUL = 5'd4;
  localparam opcode_t OP_AND = 5'd6;
  localparam opcode_t OP_NOT = 5'd11;
  localparam opcode_t OP_JMP = 5'd12;
  localparam opcode_t OP_JC  = 5'd13;
  localparam opcode_t OP_JNC = 5'd14;
  localparam opcode_t OP_JS  = 5'd15;
  localparam opcode_t OP_JNS = 5'd16;
  localparam opcode_t OP_JZ  = 5'd17;
  localparam opcode_t OP_JNZ = 5'd18;
  localparam opcode_t OP_JV  = 5'd19;
  localparam opcode_t OP_JNV = 5'd20;
  localparam opcode_t OP_HLT = 5'd21;

  // flags_i is {sign, zero, overflow, carry}
  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_EXEC,
    ST_NEXT,
    ST_HALT
  } state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Program-memory and datapath connection of the sequencer.
interface instr_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int INSN_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [INSN_W-1:0] imem_rdata;
  logic [INSN_W-1:0] ir_o;
  logic              exec_en;
  logic [3:0]        flags_i;

  modport master (
    output imem_addr,
    output ir_o,
    output exec_en,
    input  imem_rdata,
    input  flags_i
  );

  modport slave (
    input  imem_addr,
    input  ir_o,
    input  exec_en,
    output imem_rdata,
    output flags_i
  );
endinterface

// File: rtl/instr_sequencer_branch_eval.sv
// Classifies sequencer-owned opcodes and resolves jump conditions
// against the stored flag register.
module branch_eval
  import proc_pkg::*;
(
  input  opcode_t    oper_type,
  input  logic [3:0] flags,
  output logic       is_jump,
  output logic       taken,
  output logic       is_halt
);

  always_comb begin
    is_jump = 1'b1;
    taken   = 1'b0;
    is_halt = 1'b0;
    case (oper_type)
      OP_JMP:  taken = 1'b1;
      OP_JC:   taken = flags[FLAG_C];
      OP_JNC:  taken = ~flags[FLAG_C];
      OP_JS:   taken = flags[FLAG_S];
      OP_JNS:  taken = ~flags[FLAG_S];
      OP_JZ:   taken = flags[FLAG_Z];
      OP_JNZ:  taken = ~flags[FLAG_Z];
      OP_JV:   taken = flags[FLAG_V];
      OP_JNV:  taken = ~flags[FLAG_V];
      OP_HLT: begin
        is_jump = 1'b0;
        is_halt = 1'b1;
      end
      default: is_jump = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/load/exec/next controller: walks program memory, strobes the datapath
// and resolves jumps and halt locally.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSN_W = DEF_INSN_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  instr_sequencer_if.master  bus,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INSN_W-1:0] ir_q, ir_d;
  logic [3:0]        flags_q, flags_d;
  logic              armed_q, armed_d;

  opcode_t oper_type;
  logic    is_jump, taken, is_halt;
  logic    start_ok;

  assign oper_type = ir_q[OPER_HI:OPER_LO];
  // armed_q keeps a start that coincides with reset release from being taken
  assign start_ok  = start & armed_q;

  branch_eval u_branch_eval (
    .oper_type (oper_type),
    .flags     (flags_q),
    .is_jump   (is_jump),
    .taken     (taken),
    .is_halt   (is_halt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_EXEC;
      ST_EXEC:  state_d = is_halt ? ST_HALT : ST_NEXT;
      ST_NEXT:  state_d = ST_FETCH;
      ST_HALT:  if (start_ok) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    armed_d = 1'b1;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_ok) begin
          pc_d    = '0;
          flags_d = '0;
        end
      end
      ST_LOAD: ir_d = bus.imem_rdata;
      ST_NEXT: begin
        // jumps leave the flags of the last datapath op in place
        if (!is_jump) flags_d = bus.flags_i;
        pc_d = taken ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.exec_en = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_FETCH, ST_LOAD, ST_NEXT: busy = 1'b1;
      ST_EXEC: begin
        busy        = 1'b1;
        bus.exec_en = ~is_jump & ~is_halt;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.imem_addr = pc_q;
  assign bus.ir_o      = ir_q;
  assign pc            = pc_q;

endmodule
